// File: rtl/bcd_addsub_seq.sv
// Digit-serial N-digit BCD adder/subtractor, LSD first, with a start/busy/done handshake.
// Optional input digit validation is enabled by defining BCD_ADDSUB_DIGIT_CHECK_EN.
module bcd_addsub_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  cout,
    output logic                  neg,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_w;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic          r_mode;
    logic [W-1:0]  r_result;
    logic          r_cout;
    logic          r_neg;
    logic          r_err;

    logic [3:0]    w_x;
    logic [3:0]    w_y;
    logic [4:0]    w_s;
    logic          w_gt9;
    logic [3:0]    w_dig;
    logic [W-1:0]  w_w_next;
    logic          w_last;
    logic          w_fin;
    logic          w_bad_start;

    function automatic logic [W-1:0] nines_comp(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++)
            nines_comp[4*i +: 4] = 4'd9 - v[4*i +: 4];
    endfunction

`ifdef BCD_ADDSUB_DIGIT_CHECK_EN
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        has_bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) has_bad_digit = 1'b1;
    endfunction

    assign w_bad_start = (r_state == S_IDLE) && start && (has_bad_digit(a) || has_bad_digit(b));
`else
    assign w_bad_start = 1'b0;
`endif

    // One shared digit adder: CALC adds a_i + b'_i, FIX adds (9 - w_i) + 0 to form the 10's complement.
    always_comb begin
        w_x      = (r_state == S_FIX) ? (4'd9 - r_w[4*r_idx +: 4]) : r_a[4*r_idx +: 4];
        w_y      = (r_state == S_FIX) ? 4'd0 : r_b[4*r_idx +: 4];
        w_s      = {1'b0, w_x} + {1'b0, w_y} + {4'd0, r_carry};
        w_gt9    = (w_s > 5'd9);
        w_dig    = w_gt9 ? (w_s[3:0] + 4'd6) : w_s[3:0];
        w_w_next = r_w;
        w_w_next[4*r_idx +: 4] = w_dig;
    end

    assign w_last = (r_idx == IW'(DIGITS - 1));
    assign w_fin  = w_last && (((r_state == S_CALC) && (!r_mode || w_gt9)) || (r_state == S_FIX));

    // NOTE: all state below is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_w     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_mode  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= mode ? nines_comp(b) : b;
                        r_mode  <= mode;
                        r_idx   <= '0;
                        r_carry <= mode;
                        r_state <= w_bad_start ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    r_w     <= w_w_next;
                    r_carry <= w_gt9;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        if (!r_mode || w_gt9) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_FIX;
                            r_idx   <= '0;
                            r_carry <= 1'b1;
                        end
                    end
                end
                S_FIX: begin
                    r_w     <= w_w_next;
                    r_carry <= w_gt9;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Visible outputs only change on the edge entering DONE, so partial digits never leak out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_bad_start) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_neg    <= 1'b0;
            r_err    <= 1'b1;
        end else if (w_fin) begin
            r_result <= w_w_next;
            r_cout   <= !r_mode && w_gt9;
            r_neg    <= (r_state == S_FIX);
            r_err    <= 1'b0;
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign cout   = r_cout;
    assign neg    = r_neg;
`ifdef BCD_ADDSUB_DIGIT_CHECK_EN
    assign err    = r_err;
`else
    assign err    = 1'b0;
`endif

endmodule
